// File: rtl/b10_link_peer.sv
// b10_link_peer: far-end station that receives vote words over RTR/CTS, buffers them in a FIFO
// and returns them over RTS/CTR. Optional handshake watchdog: define LINK_TIMEOUT_EN.
module b10_link_peer #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [3:0]  REPLY_MASK = 4'b0000,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic                    CTS,
  input  logic [3:0]              V_OUT,
  input  logic                    CTR,
  output logic                    RTR,
  output logic                    RTS,
  output logic [3:0]              V_IN,
  output logic [$clog2(DEPTH):0]  FIFO_LEVEL,
  output logic                    TIMEOUT_ERR
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  // Reject configurations the pointer arithmetic cannot represent.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("b10_link_peer: DEPTH must be a power of two in 2..16 and TIMEOUT >= 1");
  end

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SETUP = 2'd1,
    TX_REQ   = 2'd2,
    TX_DONE  = 2'd3
  } tx_state_e;

  rx_state_e        rx_state_q, rx_state_d;
  tx_state_e        tx_state_q, tx_state_d;
  logic             rtr_q, rtr_d;
  logic             rts_q, rts_d;
  logic [3:0]       v_in_q, v_in_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       mem_q [DEPTH];

  logic push_c, pop_c, load_c, full_c, empty_c;
  logic rx_to_c, tx_to_c;

  assign full_c  = (level_q == LVL_W'(DEPTH));
  assign empty_c = (level_q == '0);
  // A push needs RTR already offered; a pop is the controller's CTR during the request.
  assign push_c  = (rx_state_q == RX_IDLE) && rtr_q && CTS;
  assign pop_c   = (tx_state_q == TX_REQ) && CTR;
  assign load_c  = (tx_state_q == TX_IDLE) && (tx_state_d == TX_SETUP);

`ifdef LINK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             err_q, err_d;

  // A timeout only fires when the normal exit condition is not present on the same edge.
  assign rx_to_c = (rx_state_q == RX_ACK) && CTS && (rx_cnt_q == CNT_W'(TIMEOUT - 1));
  assign tx_to_c = (tx_cnt_q == CNT_W'(TIMEOUT - 1)) &&
                   (((tx_state_q == TX_REQ) && !CTR) || ((tx_state_q == TX_DONE) && CTR));

  always_comb begin
    rx_cnt_d = '0;
    tx_cnt_d = '0;
    err_d    = err_q | rx_to_c | tx_to_c;
    if ((rx_state_q == RX_ACK) && (rx_state_d == rx_state_q)) begin
      rx_cnt_d = rx_cnt_q + CNT_W'(1);
    end
    if (((tx_state_q == TX_REQ) || (tx_state_q == TX_DONE)) && (tx_state_d == tx_state_q)) begin
      tx_cnt_d = tx_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      err_q    <= err_d;
    end
  end

  assign TIMEOUT_ERR = err_q;
`else
  assign rx_to_c     = 1'b0;
  assign tx_to_c     = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

  // State and registered-output storage.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      rx_state_q <= RX_IDLE;
      tx_state_q <= TX_IDLE;
      rtr_q      <= 1'b0;
      rts_q      <= 1'b0;
      v_in_q     <= 4'b0000;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      rtr_q      <= rtr_d;
      rts_q      <= rts_d;
      v_in_q     <= v_in_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Word storage carries no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge CLOCK) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= V_OUT;
    end
  end

  // RX next state.
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE: if (push_c) rx_state_d = RX_ACK;
      RX_ACK:  if (!CTS || rx_to_c) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX next state.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  if (ENABLE && !empty_c) tx_state_d = TX_SETUP;
      TX_SETUP: tx_state_d = TX_REQ;
      TX_REQ: begin
        if (CTR) begin
          tx_state_d = TX_DONE;
        end else if (tx_to_c) begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_DONE:  if (!CTR || tx_to_c) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // Output and FIFO bookkeeping; RTR is withdrawn on the accepting edge itself.
  always_comb begin
    rtr_d    = 1'b0;
    rts_d    = 1'b0;
    v_in_d   = v_in_q;
    level_d  = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    if ((rx_state_q == RX_IDLE) && ENABLE && !full_c && !push_c) begin
      rtr_d = 1'b1;
    end
    if (tx_state_d == TX_REQ) begin
      rts_d = 1'b1;
    end
    if (load_c) begin
      v_in_d = mem_q[rd_ptr_q] ^ REPLY_MASK;
    end
  end

  assign RTR        = rtr_q;
  assign RTS        = rts_q;
  assign V_IN       = v_in_q;
  assign FIFO_LEVEL = level_q;

endmodule
